// File: rtl/adv7611_cfg_sequencer.sv
// ADV7611 configuration sequencer: walks the {dev,reg,data} LUT and issues one I2C
// byte-write per entry, with power-up wait, inter-write gap, soft-reset wait and NACK retry.
module adv7611_cfg_sequencer #(
  parameter int unsigned POWERUP_CYC  = 1_000_000,
  parameter int unsigned GAP_CYC      = 1000,
  parameter int unsigned RST_WAIT_CYC = 500_000,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_start,
  output logic [8:0]  lut_index,
  input  logic [23:0] lut_data,
  input  logic [8:0]  lut_size,
  output logic        i2c_req,
  output logic [7:0]  i2c_dev,
  output logic [7:0]  i2c_reg,
  output logic [7:0]  i2c_wdata,
  input  logic        i2c_done,
  input  logic        i2c_ack,
  output logic        cfg_busy,
  output logic        cfg_done,
  output logic        cfg_error,
  output logic [8:0]  err_index
);

  localparam int unsigned WAIT_MAX_A = (POWERUP_CYC > GAP_CYC) ? POWERUP_CYC : GAP_CYC;
  localparam int unsigned WAIT_MAX   = (WAIT_MAX_A > RST_WAIT_CYC) ? WAIT_MAX_A : RST_WAIT_CYC;
  localparam int unsigned WAIT_W     = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam int unsigned RETRY_W    = $clog2(MAX_RETRY + 1);

  localparam logic [WAIT_W-1:0]  PWR_LAST  = WAIT_W'((POWERUP_CYC > 0) ? POWERUP_CYC - 1 : 0);
  localparam logic [WAIT_W-1:0]  GAP_LAST  = WAIT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [WAIT_W-1:0]  RST_LAST  = WAIT_W'((RST_WAIT_CYC > 0) ? RST_WAIT_CYC - 1 : 0);
  localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(MAX_RETRY);

  typedef enum logic [3:0] {
    S_PWR_WAIT,
    S_FETCH,
    S_ISSUE,
    S_WAIT_RESP,
    S_RETRY_WAIT,
    S_GAP,
    S_RST_WAIT,
    S_DONE,
    S_ERROR
  } state_t;

  state_t             state;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [RETRY_W-1:0] retry_cnt;
  logic               soft_rst;
  logic               is_last;
  logic               wait_end;

  assign soft_rst = (i2c_dev == 8'h98) && (i2c_reg == 8'hFF) && i2c_wdata[7];
  assign is_last  = (lut_index >= (lut_size - 9'd1));
  assign wait_end = ((state == S_GAP)      && (wait_cnt == GAP_LAST)) ||
                    ((state == S_RST_WAIT) && (wait_cnt == RST_LAST));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_PWR_WAIT;
      wait_cnt  <= '0;
      retry_cnt <= '0;
      lut_index <= '0;
      i2c_req   <= 1'b0;
      i2c_dev   <= '0;
      i2c_reg   <= '0;
      i2c_wdata <= '0;
      cfg_busy  <= 1'b1;
      cfg_done  <= 1'b0;
      cfg_error <= 1'b0;
      err_index <= '0;
    end else begin
      case (state)
        S_PWR_WAIT: begin
          if (wait_cnt == PWR_LAST) begin
            wait_cnt <= '0;
            if (lut_size == '0) begin
              state    <= S_DONE;
              cfg_busy <= 1'b0;
              cfg_done <= 1'b1;
            end else begin
              state <= S_FETCH;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        // Request is raised on the fetch edge so it is already visible while in ISSUE.
        S_FETCH: begin
          {i2c_dev, i2c_reg, i2c_wdata} <= lut_data;
          retry_cnt <= '0;
          i2c_req   <= 1'b1;
          state     <= S_ISSUE;
        end
        S_ISSUE: state <= S_WAIT_RESP;
        S_WAIT_RESP: begin
          if (i2c_done) begin
            i2c_req  <= 1'b0;
            wait_cnt <= '0;
            if (i2c_ack) begin
              state <= soft_rst ? S_RST_WAIT : S_GAP;
            end else if ((retry_cnt + 1'b1) == RETRY_LIM) begin
              state     <= S_ERROR;
              cfg_busy  <= 1'b0;
              cfg_error <= 1'b1;
              err_index <= lut_index;
            end else begin
              retry_cnt <= retry_cnt + 1'b1;
              state     <= S_RETRY_WAIT;
            end
          end
        end
        S_RETRY_WAIT: begin
          if (wait_cnt == GAP_LAST) begin
            wait_cnt <= '0;
            i2c_req  <= 1'b1;
            state    <= S_ISSUE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_GAP, S_RST_WAIT: begin
          if (wait_end) begin
            wait_cnt <= '0;
            if (is_last) begin
              state    <= S_DONE;
              cfg_busy <= 1'b0;
              cfg_done <= 1'b1;
            end else begin
              lut_index <= lut_index + 9'd1;
              state     <= S_FETCH;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_DONE, S_ERROR: begin
          if (cfg_start) begin
            state     <= S_PWR_WAIT;
            wait_cnt  <= '0;
            lut_index <= '0;
            cfg_busy  <= 1'b1;
            cfg_done  <= 1'b0;
            cfg_error <= 1'b0;
            err_index <= '0;
          end
        end
        default: state <= S_PWR_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_adv7611_cfg_sequencer.sv
// Self-checking bench for adv7611_cfg_sequencer: I2C engine model with scripted NACKs,
// and a transaction-level timing model of the expected write sequence.
module tb_adv7611_cfg_sequencer;

  localparam int P_PWR   = 16;
  localparam int P_GAP   = 4;
  localparam int P_RST   = 32;
  localparam int P_RETRY = 3;
  localparam int ENG_LAT = 10;

  logic        clk;
  logic        rst_n;
  logic        cfg_start;
  logic [8:0]  lut_index;
  logic [23:0] lut_data;
  logic [8:0]  lut_size;
  logic        i2c_req;
  logic [7:0]  i2c_dev;
  logic [7:0]  i2c_reg;
  logic [7:0]  i2c_wdata;
  logic        i2c_done;
  logic        i2c_ack;
  logic        cfg_busy;
  logic        cfg_done;
  logic        cfg_error;
  logic [8:0]  err_index;

  adv7611_cfg_sequencer #(
    .POWERUP_CYC (P_PWR),
    .GAP_CYC     (P_GAP),
    .RST_WAIT_CYC(P_RST),
    .MAX_RETRY   (P_RETRY)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_start (cfg_start),
    .lut_index (lut_index),
    .lut_data  (lut_data),
    .lut_size  (lut_size),
    .i2c_req   (i2c_req),
    .i2c_dev   (i2c_dev),
    .i2c_reg   (i2c_reg),
    .i2c_wdata (i2c_wdata),
    .i2c_done  (i2c_done),
    .i2c_ack   (i2c_ack),
    .cfg_busy  (cfg_busy),
    .cfg_done  (cfg_done),
    .cfg_error (cfg_error),
    .err_index (err_index)
  );

  typedef struct {
    int          t;
    int          idx;
    logic [23:0] pay;
  } att_t;

  logic [23:0] lut_mem [0:511];
  int          nack_cnt [0:511];
  int          att_cnt  [0:511];
  att_t        obs_q[$];
  att_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc;
  int          stab_err;
  int          exp_end;
  int          exp_err;
  int          exp_err_idx;

  assign lut_data = lut_mem[lut_index];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge counter: value k after the k-th rising edge since reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // I2C engine model: logs each request, answers ENG_LAT edges later.
  initial begin : engine
    bit          busy;
    int          t0;
    logic [23:0] pay;
    bit          ack;
    busy     = 0;
    i2c_done = 1'b0;
    i2c_ack  = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy     = 0;
        i2c_done = 1'b0;
      end else if (i2c_done) begin
        i2c_done = 1'b0;
        busy     = 0;
      end else if (busy) begin
        if (!i2c_req || {i2c_dev, i2c_reg, i2c_wdata} != pay) stab_err++;
        if (cyc == t0 + ENG_LAT - 1) begin
          i2c_done = 1'b1;
          i2c_ack  = ack;
        end
      end else if (i2c_req) begin
        busy = 1;
        t0   = cyc;
        pay  = {i2c_dev, i2c_reg, i2c_wdata};
        att_cnt[lut_index]++;
        ack  = (att_cnt[lut_index] > nack_cnt[lut_index]);
        obs_q.push_back('{cyc, int'(lut_index), pay});
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_soft(input logic [23:0] e);
    return (e[23:16] == 8'h98) && (e[15:8] == 8'hFF) && e[7];
  endfunction

  // Expected writes derived from the LUT, NACK script and the published timing rules.
  task automatic build_model(input int s0, input int size);
    int          t;
    int          n;
    int          w;
    logic [23:0] e;
    exp_q.delete();
    exp_err     = 0;
    exp_err_idx = 0;
    if (size == 0) begin
      exp_end = s0 + P_PWR;
      return;
    end
    t = s0 + P_PWR + 1;
    for (int i = 0; i < size; i++) begin
      e = lut_mem[i];
      n = 0;
      forever begin
        exp_q.push_back('{t, i, e});
        n++;
        if (n > nack_cnt[i]) break;
        if (n == P_RETRY) begin
          exp_err     = 1;
          exp_err_idx = i;
          exp_end     = t + ENG_LAT;
          return;
        end
        t = t + ENG_LAT + P_GAP;
      end
      w = is_soft(e) ? P_RST : P_GAP;
      if (i == size - 1) exp_end = t + ENG_LAT + w;
      else               t = t + ENG_LAT + w + 1;
    end
  endtask

  task automatic clear_logs();
    obs_q.delete();
    stab_err = 0;
    for (int i = 0; i < 512; i++) att_cnt[i] = 0;
  endtask

  task automatic fill_lut(input int size, input bit allow_soft);
    lut_size = 9'(size);
    for (int i = 0; i < 512; i++) begin
      lut_mem[i] = 24'($urandom);
      if (!allow_soft && is_soft(lut_mem[i])) lut_mem[i][23] = 1'b0;
      nack_cnt[i] = 0;
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n     = 1'b0;
    cfg_start = 1'b0;
    #1;
    check({tag, "_rst_req"},   i2c_req,   0);
    check({tag, "_rst_idx"},   lut_index, 0);
    check({tag, "_rst_addr"},  {i2c_dev, i2c_reg, i2c_wdata}, 0);
    check({tag, "_rst_busy"},  cfg_busy,  1);
    check({tag, "_rst_flags"}, {cfg_done, cfg_error}, 0);
    check({tag, "_rst_eidx"},  err_index, 0);
    repeat (2) @(negedge clk);
    clear_logs();
    rst_n = 1'b1;
  endtask

  task automatic run_and_check(input string tag, input int s0, input int size);
    int to;
    int n;
    build_model(s0, size);
    to = 0;
    while (!(cfg_done || cfg_error) && to < 5000) begin
      @(negedge clk);
      to++;
    end
    check({tag, "_finished"}, (to < 5000), 1);
    check({tag, "_end_edge"}, cyc, exp_end);
    check({tag, "_done"},  cfg_done,  !exp_err);
    check({tag, "_error"}, cfg_error, exp_err);
    check({tag, "_busy"},  cfg_busy,  0);
    if (exp_err != 0) begin
      check({tag, "_err_index"}, err_index, exp_err_idx);
      check({tag, "_idx_frozen"}, lut_index, exp_err_idx);
    end
    repeat (40) @(negedge clk);
    check({tag, "_num_req"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int k = 0; k < n; k++) begin
      check($sformatf("%s_req%0d_time", tag, k), obs_q[k].t,   exp_q[k].t);
      check($sformatf("%s_req%0d_idx",  tag, k), obs_q[k].idx, exp_q[k].idx);
      check($sformatf("%s_req%0d_data", tag, k), obs_q[k].pay, exp_q[k].pay);
    end
    check({tag, "_stable"}, stab_err, 0);
  endtask

  task automatic pulse_start(output int s0);
    @(negedge clk);
    cfg_start = 1'b1;
    s0 = cyc + 1;
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  initial begin : stim
    int s0;
    int sz;
    int to;
    rst_n     = 1'b0;
    cfg_start = 1'b0;
    lut_size  = '0;
    stab_err  = 0;
    for (int i = 0; i < 512; i++) begin
      lut_mem[i]  = '0;
      nack_cnt[i] = 0;
      att_cnt[i]  = 0;
    end

    // T1: three plain entries, all ACKed
    fill_lut(3, 0);
    do_reset("t1");
    run_and_check("t1", 0, 3);

    // T2: entry 1 is the soft-reset write
    fill_lut(4, 0);
    lut_mem[1] = 24'h98FF80;
    do_reset("t2");
    run_and_check("t2", 0, 4);

    // T3: entry 2 NACKs twice, then ACKs
    fill_lut(4, 0);
    nack_cnt[2] = 2;
    do_reset("t3");
    run_and_check("t3", 0, 4);

    // T4: entry 5 always NACKs -> error; restart runs the whole LUT again
    fill_lut(7, 0);
    nack_cnt[5] = 3;
    do_reset("t4");
    run_and_check("t4", 0, 7);
    nack_cnt[5] = 0;
    clear_logs();
    pulse_start(s0);
    check("t4_restart_busy",  cfg_busy, 1);
    check("t4_restart_flags", {cfg_done, cfg_error}, 0);
    check("t4_restart_eidx",  err_index, 0);
    check("t4_restart_idx",   lut_index, 0);
    run_and_check("t4_rerun", s0, 7);

    // T5: empty LUT; a start pulse while busy must not disturb the power-up wait
    fill_lut(0, 0);
    do_reset("t5");
    repeat (5) @(negedge clk);
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    run_and_check("t5", 0, 0);

    // T6: reset while a request is outstanding
    fill_lut(5, 1);
    do_reset("t6a");
    to = 0;
    while (!i2c_req && to < 200) begin
      @(negedge clk);
      to++;
    end
    check("t6_req_seen", i2c_req, 1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("t6_req_async_drop", i2c_req, 0);
    do_reset("t6b");
    run_and_check("t6", 0, 5);

    // Randomised LUTs: random sizes, NACK scripts and soft-reset entries
    for (int r = 0; r < 5; r++) begin
      sz = $urandom_range(1, 8);
      fill_lut(sz, 1);
      for (int i = 0; i < sz; i++) begin
        if ($urandom_range(0, 3) == 0) nack_cnt[i] = $urandom_range(1, 3);
        if ($urandom_range(0, 5) == 0) lut_mem[i] = {16'h98FF, 1'b1, 7'($urandom)};
      end
      do_reset($sformatf("rnd%0d", r));
      run_and_check($sformatf("rnd%0d", r), 0, sz);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
